// File: rtl/result_bus_arbiter.sv
// Result bus (CDB) arbiter: round-robin selection of one execution-unit result per cycle
// into a registered bus slot with ready/valid handshakes on both sides.

package result_bus_arbiter_pkg;
    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;
endpackage

module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_UNITS   = 4,
    parameter  int unsigned RS_ID_WIDTH = 5,
    localparam int unsigned UNIT_W      = $clog2(NUM_UNITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_UNITS-1:0]   unit_valid,
    output logic [NUM_UNITS-1:0]   unit_ready,
    input  logic [RS_ID_WIDTH-1:0] unit_rs_id    [NUM_UNITS],
    input  logic [4:0]             unit_reg_addr [NUM_UNITS],
    input  logic [31:0]            unit_result   [NUM_UNITS],
    input  cond_exception_t        unit_cr0_xer  [NUM_UNITS],
    output logic                   cdb_valid,
    input  logic                   cdb_ready,
    output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    output logic [4:0]             cdb_reg_addr,
    output logic [31:0]            cdb_result,
    output cond_exception_t        cdb_cr0_xer,
    output logic [UNIT_W-1:0]      cdb_unit
);

    logic [UNIT_W-1:0] ptr;
    logic [UNIT_W-1:0] cand_idx;
    logic [UNIT_W-1:0] win_idx;
    logic              win_found;
    logic              slot_free;

    assign slot_free = !cdb_valid || cdb_ready;

    // First valid unit at or after ptr, wrapping; independent of cdb_ready.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            cand_idx = UNIT_W'((32'(ptr) + i) % NUM_UNITS);
            if (!win_found && unit_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // rst gates the grant so no unit sees a handshake while reset is held.
    always_comb begin
        unit_ready = '0;
        if (rst && slot_free && win_found) begin
            unit_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid    <= 1'b0;
            cdb_rs_id    <= '0;
            cdb_reg_addr <= '0;
            cdb_result   <= '0;
            cdb_cr0_xer  <= '0;
            cdb_unit     <= '0;
            ptr          <= '0;
        end else if (slot_free) begin
            if (win_found) begin
                cdb_valid    <= 1'b1;
                cdb_rs_id    <= unit_rs_id[win_idx];
                cdb_reg_addr <= unit_reg_addr[win_idx];
                cdb_result   <= unit_result[win_idx];
                cdb_cr0_xer  <= unit_cr0_xer[win_idx];
                cdb_unit     <= win_idx;
                ptr          <= (win_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed table-driven bench for result_bus_arbiter with 4 units, plus an async-reset sequence.

module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N-1:0]        unit_valid = '0;
    logic [N-1:0]        unit_ready;
    logic [4:0]          unit_rs_id    [N];
    logic [4:0]          unit_reg_addr [N];
    logic [31:0]         unit_result   [N];
    cond_exception_t     unit_cr0_xer  [N];
    logic                cdb_valid;
    logic                cdb_ready = 1'b0;
    logic [4:0]          cdb_rs_id;
    logic [4:0]          cdb_reg_addr;
    logic [31:0]         cdb_result;
    cond_exception_t     cdb_cr0_xer;
    logic [1:0]          cdb_unit;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    result_bus_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .unit_valid(unit_valid), .unit_ready(unit_ready),
        .unit_rs_id(unit_rs_id), .unit_reg_addr(unit_reg_addr),
        .unit_result(unit_result), .unit_cr0_xer(unit_cr0_xer),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_rs_id(cdb_rs_id), .cdb_reg_addr(cdb_reg_addr),
        .cdb_result(cdb_result), .cdb_cr0_xer(cdb_cr0_xer),
        .cdb_unit(cdb_unit)
    );

    always #5 clk = ~clk;

    // Fixed per-unit payloads; unit 2 carries the DEADBEEF / rs_id 9 result.
    logic [4:0]  exp_rs   [N] = '{5'd3, 5'd17, 5'd9, 5'd30};
    logic [4:0]  exp_reg  [N] = '{5'd1, 5'd5, 5'd10, 5'd31};
    logic [31:0] exp_res  [N] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
    logic [6:0]  exp_flag [N] = '{7'h01, 7'h12, 7'h25, 7'h7F};

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        crdy;
        logic [3:0]  exp_ready;
        logic        exp_cv;
        int unsigned exp_unit;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_bus(input string tag, input logic cv, input int unsigned u);
        check({tag, " cdb_valid"}, 64'(cdb_valid), 64'(cv));
        if (cv) begin
            check({tag, " cdb_unit"}, 64'(cdb_unit), 64'(u));
            check({tag, " cdb_data"},
                  64'({cdb_rs_id, cdb_reg_addr, cdb_result, 7'(cdb_cr0_xer)}),
                  64'({exp_rs[u], exp_reg[u], exp_res[u], exp_flag[u]}));
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            unit_rs_id[i]    = exp_rs[i];
            unit_reg_addr[i] = exp_reg[i];
            unit_result[i]   = exp_res[i];
            unit_cr0_xer[i]  = exp_flag[i];
        end

        //          rst   valid    crdy  ready    cv    unit
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0}; // held in reset
        vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0}; // first grant after release
        vecs[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0}; // wrap 3 -> 0
        vecs[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0}; // drain, ptr stays 1
        vecs[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        vecs[8]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2}; // single req, ptr -> 3
        vecs[9]  = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 0}; // ptr 3, skip to 0
        vecs[10] = '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 1}; // ptr -> 2
        vecs[11] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1}; // backpressure x3
        vecs[12] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1};
        vecs[13] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1};
        vecs[14] = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 3}; // drain+refill, ptr 2 -> 3
        vecs[15] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
        vecs[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        vecs[17] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 0}; // empty slot ignores cdb_ready
        vecs[18] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 0};
        vecs[19] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};

        #1;
        check("reset cdb_valid", 64'(cdb_valid), 64'd0);
        check("reset unit_ready", 64'(unit_ready), 64'd0);

        for (int v = 0; v < 20; v++) begin
            @(negedge clk);
            rst        = vecs[v].rst;
            unit_valid = vecs[v].valid;
            cdb_ready  = vecs[v].crdy;
            #1;
            check($sformatf("v%0d unit_ready", v), 64'(unit_ready), 64'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            check_bus($sformatf("v%0d", v), vecs[v].exp_cv, vecs[v].exp_unit);
        end

        // Async reset between edges while the bus holds unit 1 (ptr was 1).
        @(negedge clk);
        unit_valid = 4'b1111;
        cdb_ready  = 1'b1;
        @(posedge clk);
        #1;
        check_bus("pre-reset", 1'b1, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async cdb_valid", 64'(cdb_valid), 64'd0);
        check("async cdb_data", 64'({cdb_rs_id, cdb_reg_addr, cdb_result, 7'(cdb_cr0_xer), cdb_unit}), 64'd0);
        check("async unit_ready", 64'(unit_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-reset unit_ready", 64'(unit_ready), 64'b0001);
        @(posedge clk);
        #1;
        check_bus("post-reset", 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
